// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the FP adder scheduler.
// The FP_WATCHDOG_EN build option is consumed by fp_add_scheduler.
package fp_sched_pkg;

    // Custom FP word layout: sign[31], exp[30:25], mant[24:0]
    localparam int unsigned FP_WIDTH   = 32;
    localparam int unsigned EXP_MSB    = 30;
    localparam int unsigned EXP_LSB    = 25;
    localparam int unsigned MANT_WIDTH = 25;

    // Response status codes
    localparam logic [3:0] ST_EXACT   = 4'd0;
    localparam logic [3:0] ST_OVF     = 4'd1;
    localparam logic [3:0] ST_UNF     = 4'd2;
    localparam logic [3:0] ST_INEXACT = 4'd3;
    localparam logic [3:0] ST_TIMEOUT = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } sched_state_t;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Produces one-hot grant, its index and an any flag.
module fp_rr_arbiter
    import fp_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] cand;

    // Scan from the pointer outward; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!grant_any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one multi-cycle FP adder between NUM_REQ requesters using
// round-robin arbitration: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
// Optional build macro FP_WATCHDOG_EN adds a WAIT-state timeout that
// answers with rsp_data=0 and status ST_TIMEOUT.
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clock_100kHz,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_op_a,
    input  logic [NUM_REQ*32-1:0]  req_op_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic [3:0]             rsp_status,
    output logic [31:0]            fpu_op_a,
    output logic [31:0]            fpu_op_b,
    output logic                   fpu_start,
    input  logic                   fpu_done,
    input  logic [31:0]            fpu_result,
    input  logic [3:0]             fpu_status,
    output logic                   busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    sched_state_t        state, state_nxt;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    gnt_q;
    logic [FP_WIDTH-1:0] sel_a, sel_b;
    logic                wd_expired;

    fp_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Select the operand slices of the arbitration winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_a = req_op_a[FP_WIDTH*i +: FP_WIDTH];
                sel_b = req_op_b[FP_WIDTH*i +: FP_WIDTH];
            end
        end
    end

`ifdef FP_WATCHDOG_EN
    logic [6:0] wd_cnt;

    // Watchdog counts WAIT cycles; it sits at zero outside WAIT, so it is
    // cleared on every entry to WAIT.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset)
            wd_cnt <= '0;
        else if (state != S_WAIT)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 7'd1;
    end

    // Fires in the TIMEOUT_CYCLES-th WAIT cycle so WAIT lasts exactly that long.
    assign wd_expired = (state == S_WAIT) && (wd_cnt == 7'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and per-state control pulses.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        fpu_start = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (arb_any) begin
                    req_ready = arb_grant;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fpu_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (fpu_done || wd_expired)
                    state_nxt = S_RESPOND;
            end
            S_RESPOND: begin
                rsp_valid[gnt_q] = 1'b1;
                state_nxt        = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture on grant, result capture in WAIT, rr pointer advance.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            gnt_q      <= '0;
            fpu_op_a   <= '0;
            fpu_op_b   <= '0;
            rsp_data   <= '0;
            rsp_status <= '0;
        end else begin
            if (state == S_IDLE && arb_any) begin
                gnt_q    <= arb_idx;
                fpu_op_a <= sel_a;
                fpu_op_b <= sel_b;
                rr_ptr   <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (state == S_WAIT) begin
                if (fpu_done) begin
                    rsp_data   <= fpu_result;
                    rsp_status <= fpu_status;
                end else if (wd_expired) begin
                    rsp_data   <= '0;
                    rsp_status <= ST_TIMEOUT;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler: directed scenarios plus a
// randomized phase, checked against a round-robin reference model and a
// behavioural adder driven by the bench.
module tb_fp_add_scheduler;
    import fp_sched_pkg::*;

    localparam int NR = 4;

    logic              clock_100kHz;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*32-1:0]  req_op_a;
    logic [NR*32-1:0]  req_op_b;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [31:0]       rsp_data;
    logic [3:0]        rsp_status;
    logic [31:0]       fpu_op_a;
    logic [31:0]       fpu_op_b;
    logic              fpu_start;
    logic              fpu_done;
    logic [31:0]       fpu_result;
    logic [3:0]        fpu_status;
    logic              busy;

    int errors = 0;
    int checks = 0;
    int rr_m   = 0;
    logic [31:0] op_a_m [NR];
    logic [31:0] op_b_m [NR];

    fp_add_scheduler #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_op_a     (req_op_a),
        .req_op_b     (req_op_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_status   (rsp_status),
        .fpu_op_a     (fpu_op_a),
        .fpu_op_b     (fpu_op_b),
        .fpu_start    (fpu_start),
        .fpu_done     (fpu_done),
        .fpu_result   (fpu_result),
        .fpu_status   (fpu_status),
        .busy         (busy)
    );

    initial clock_100kHz = 1'b0;
    always #5 clock_100kHz = ~clock_100kHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first pending requester at or after rr, modulo NR.
    function automatic int pick(input logic [NR-1:0] v, input int rr);
        for (int off = 0; off < NR; off++) begin
            int idx;
            idx = (rr + off) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic load_ops();
        for (int i = 0; i < NR; i++) begin
            req_op_a[32*i +: 32] = op_a_m[i];
            req_op_b[32*i +: 32] = op_b_m[i];
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"},      32'(busy),       32'd0);
        chk({tag, "_start"},     32'(fpu_start),  32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid),  32'd0);
        chk({tag, "_op_a"},      fpu_op_a,        32'd0);
        chk({tag, "_op_b"},      fpu_op_b,        32'd0);
        chk({tag, "_rsp_data"},  rsp_data,        32'd0);
        chk({tag, "_rsp_stat"},  32'(rsp_status), 32'd0);
    endtask

    // One full transaction starting at a negedge in IDLE with req_valid set.
    // delay = WAIT cycle (1-based) in which fpu_done is raised.
    task automatic run_op(input int delay, input bit early_done,
                          input logic [31:0] res, input logic [3:0] st);
        int g;
        logic [31:0] ea, eb;
        #1;
        g = pick(req_valid, rr_m);
        if (g < 0) begin
            chk("no_pending", 32'(req_ready), 32'd0);
            return;
        end
        chk("req_ready", 32'(req_ready), 32'd1 << g);
        chk("busy_idle", 32'(busy), 32'd0);
        ea   = op_a_m[g];
        eb   = op_b_m[g];
        rr_m = (g + 1) % NR;
        @(negedge clock_100kHz);
        if (early_done) begin
            fpu_done   = 1'b1;
            fpu_result = 32'hDEAD_BEEF;
            fpu_status = 4'hF;
        end
        #1;
        chk("issue_start", 32'(fpu_start), 32'd1);
        chk("issue_op_a",  fpu_op_a, ea);
        chk("issue_op_b",  fpu_op_b, eb);
        chk("issue_ready", 32'(req_ready), 32'd0);
        @(negedge clock_100kHz);
        fpu_done = 1'b0;
        #1;
        chk("wait_start", 32'(fpu_start), 32'd0);
        for (int k = 1; k < delay; k++) begin
            chk("wait_rsp", 32'(rsp_valid), 32'd0);
            chk("wait_hold_a", fpu_op_a, ea);
            @(negedge clock_100kHz);
            #1;
        end
        fpu_done   = 1'b1;
        fpu_result = res;
        fpu_status = st;
        @(negedge clock_100kHz);
        fpu_done   = 1'b0;
        fpu_result = 32'h0BAD_0BAD;
        fpu_status = 4'h7;
        #1;
        chk("rsp_valid",  32'(rsp_valid), 32'd1 << g);
        chk("rsp_data",   rsp_data, res);
        chk("rsp_status", 32'(rsp_status), 32'(st));
        @(negedge clock_100kHz);
        #1;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rsp_hold",  rsp_data, res);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_op_a   = '0;
        req_op_b   = '0;
        fpu_done   = 1'b0;
        fpu_result = '0;
        fpu_status = '0;
        for (int i = 0; i < NR; i++) begin
            op_a_m[i] = 32'h1000_0000 + 32'(i);
            op_b_m[i] = 32'h2000_0000 + 32'(i);
        end
        repeat (2) @(negedge clock_100kHz);
        #1;
        check_idle_zero("reset");
        chk("reset_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;

        // Single request, fpu_done 5 cycles after start.
        @(negedge clock_100kHz);
        op_a_m[0] = 32'h4200_0000;
        op_b_m[0] = 32'h4200_0000;
        load_ops();
        req_valid = 4'b0001;
        run_op(5, 1'b1, 32'h4280_0000, ST_EXACT);
        req_valid = 4'b0000;

        // Reset two cycles into WAIT: in-flight op dropped, rr back to 0.
        req_valid = 4'b0001;
        #1;
        chk("rst_t_ready", 32'(req_ready), 32'd1);
        @(negedge clock_100kHz);
        req_valid = 4'b0000;
        @(negedge clock_100kHz);
        @(negedge clock_100kHz);
        reset = 1'b1;
        #1;
        check_idle_zero("midreset");
        @(negedge clock_100kHz);
        #1;
        check_idle_zero("midreset_edge");
        reset = 1'b0;
        rr_m  = 0;

        // Two requesters held: grants 0, 2, 0.
        req_valid = 4'b0101;
        for (int n = 0; n < 3; n++) run_op(1, 1'b0, 32'h3000_0000 + 32'(n), ST_INEXACT);

        // All requesters held for 8 operations.
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) run_op(2, 1'b0, 32'h5000_0000 + 32'(n), ST_EXACT);

        // Overflow status routed to requester 3.
        req_valid = 4'b1000;
        run_op(3, 1'b0, 32'h7E00_0000, ST_OVF);

        // Randomized traffic.
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < NR; i++) begin
                op_a_m[i] = $urandom;
                op_b_m[i] = $urandom;
            end
            load_ops();
            req_valid = 4'($urandom_range(1, 15));
            run_op(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                   $urandom, 4'($urandom_range(0, 3)));
        end
        req_valid = 4'b0000;

`ifdef FP_WATCHDOG_EN
        // Adder never answers: timeout response after 64 WAIT cycles.
        begin
            int g;
            req_valid = 4'b0010;
            #1;
            g = pick(req_valid, rr_m);
            rr_m = (g + 1) % NR;
            chk("wd_ready", 32'(req_ready), 32'd1 << g);
            @(negedge clock_100kHz);
            req_valid = 4'b0000;
            @(negedge clock_100kHz);
            for (int k = 1; k < 64; k++) begin
                @(negedge clock_100kHz);
                #1;
                if (k == 63) chk("wd_no_early_rsp", 32'(rsp_valid), 32'd0);
            end
            @(negedge clock_100kHz);
            #1;
            chk("wd_rsp_valid",  32'(rsp_valid), 32'd1 << g);
            chk("wd_rsp_data",   rsp_data, 32'd0);
            chk("wd_rsp_status", 32'(rsp_status), 32'(ST_TIMEOUT));
        end
`endif

        // Back to idle after all traffic.
        @(negedge clock_100kHz);
        #1;
        chk("final_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
